// File: rtl/axi_burst_beat_generator_pkg.sv
// Shared AXI constants and helpers for the burst beat generator.
package axi_pkg;

  localparam int unsigned BEAT_CNT_W = 8;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } beat_state_e;

  function automatic int unsigned axsize_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_burst_beat_generator_if.sv
// Address-channel descriptor and per-beat output bundle for axi_burst_beat_generator.
interface axi_burst_beat_generator_if
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   axid;
  logic [ADDR_WIDTH-1:0] axaddr;
  logic [BEAT_CNT_W-1:0] axlen;
  logic [2:0]            axsize;
  logic [1:0]            axburst;
  logic                  axvalid;
  logic                  axready;

  logic [ID_WIDTH-1:0]   beatId;
  logic [ADDR_WIDTH-1:0] beatAddr;
  logic [BEAT_CNT_W-1:0] beatIdx;
  logic                  beatLast;
  logic                  beatValid;
  logic                  beatReady;
  logic                  busy;

  modport master (
    output axid, axaddr, axlen, axsize, axburst, axvalid, beatReady,
    input  axready, beatId, beatAddr, beatIdx, beatLast, beatValid, busy
  );

  modport slave (
    input  axid, axaddr, axlen, axsize, axburst, axvalid, beatReady,
    output axready, beatId, beatAddr, beatIdx, beatLast, beatValid, busy
  );
endinterface

// File: rtl/axi_next_beat_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// WRAP support is built only when AXI_BURST_WRAP_EN is defined; otherwise WRAP acts as INCR.
module axi_next_beat_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_AxSIZE = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [BEAT_CNT_W-1:0] len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next
);
  localparam int unsigned StepMaskW = 1 << MAX_AxSIZE;

  logic [StepMaskW-1:0]  step_mask;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;

  always_comb begin
    step      = ADDR_WIDTH'(axsize_bytes(size));
    step_mask = StepMaskW'(axsize_bytes(size) - 32'd1);
    aligned   = addr & ~ADDR_WIDTH'(step_mask);
    incr      = aligned + step;
  end

`ifdef AXI_BURST_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // Wrap window is (len+1)*step bytes; len is restricted to 1/3/7/15 so it is a power of two.
  always_comb begin
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  end
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next = incr;
    case (burst)
      BURST_FIXED: next = addr;
`ifdef AXI_BURST_WRAP_EN
      BURST_WRAP:  next = (aligned & ~wrap_mask) | (incr & wrap_mask);
`endif
      default:     next = incr;
    endcase
  end

endmodule

// File: rtl/axi_burst_beat_generator.sv
// Accepts one AXI AR/AW burst descriptor and emits one registered address per beat.
// Optional WRAP support: define AXI_BURST_WRAP_EN.
module axi_burst_beat_generator
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned MAX_AxSIZE = 3
) (
  input logic                      aclk,
  input logic                      resetn,
  axi_burst_beat_generator_if.slave bus
);

  beat_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_CNT_W-1:0] idx_q, idx_d;
  logic [BEAT_CNT_W-1:0] len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  axready_q, axready_d;
  logic [ADDR_WIDTH-1:0] next_addr;

  axi_next_beat_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_AxSIZE (MAX_AxSIZE)
  ) u_next_addr (
    .addr  (addr_q),
    .size  (size_q),
    .len   (len_q),
    .burst (burst_q),
    .next  (next_addr)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    last_d    = last_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    axready_d = axready_q;

    unique case (state_q)
      StIdle: begin
        // axready comes up one cycle after reset release or burst end.
        axready_d = 1'b1;
        if (bus.axvalid && axready_q) begin
          id_d      = bus.axid;
          addr_d    = bus.axaddr;
          len_d     = bus.axlen;
          size_d    = bus.axsize;
          burst_d   = bus.axburst;
          idx_d     = '0;
          last_d    = (bus.axlen == '0);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          axready_d = 1'b0;
          state_d   = StBurst;
        end
      end
      StBurst: begin
        if (valid_q && bus.beatReady) begin
          if (last_q) begin
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            last_d    = 1'b0;
            axready_d = 1'b1;
            state_d   = StIdle;
          end else begin
            idx_d  = idx_q + BEAT_CNT_W'(1);
            addr_d = next_addr;
            last_d = ((idx_q + BEAT_CNT_W'(1)) == len_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      axready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      axready_q <= axready_d;
    end
  end

  assign bus.axready   = axready_q;
  assign bus.beatId    = id_q;
  assign bus.beatAddr  = addr_q;
  assign bus.beatIdx   = idx_q;
  assign bus.beatLast  = last_q;
  assign bus.beatValid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_axi_burst_beat_generator.sv
// Self-checking bench for axi_burst_beat_generator: directed cases plus random bursts
// compared against an arithmetic address model.
module tb_axi_burst_beat_generator;
  import axi_pkg::*;

  logic aclk;
  logic resetn;

  int unsigned n_cmp;
  int unsigned n_err;

  bit fixed_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  axi_burst_beat_generator_if #(.ADDR_WIDTH(32), .ID_WIDTH(8)) bus ();

  axi_burst_beat_generator #(
    .ADDR_WIDTH (32),
    .ID_WIDTH   (8),
    .MAX_AxSIZE (3)
  ) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat k address from the burst rules: start, then aligned start + k*step,
  // folded into the wrap window for WRAP.
  function automatic logic [31:0] exp_addr(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input int k);
    logic [31:0] step;
    logic [31:0] al;
    logic [31:0] wb;
    logic [31:0] base;
    if (k == 0 || burst == BURST_FIXED) return addr;
    step = 32'd1 << size;
    al   = addr & ~(step - 32'd1);
`ifdef AXI_BURST_WRAP_EN
    if (burst == BURST_WRAP) begin
      wb   = (32'(len) + 32'd1) * step;
      base = al & ~(wb - 32'd1);
      return base + ((al - base + 32'(k) * step) % wb);
    end
`endif
    wb   = 32'd0;
    base = 32'd0;
    return al + 32'(k) * step + wb + base;
  endfunction

  task automatic send_desc(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.axid    = id;
    bus.axaddr  = addr;
    bus.axlen   = len;
    bus.axsize  = size;
    bus.axburst = burst;
    bus.axvalid = 1'b1;
    while (!bus.axready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check_eq("ax_accept_wait", 64'(n < 50), 64'd1);
    @(posedge aclk);
    #1;
    bus.axvalid = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: fixed 1,0,0,1,1 pattern
  task automatic run_beats(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           output int hs);
    int k = 0;
    int cyc = 0;
    @(negedge aclk);
    while (k <= int'(len) && cyc < 400) begin
      case (mode)
        0:       bus.beatReady = 1'b1;
        1:       bus.beatReady = 1'($urandom_range(0, 1));
        default: bus.beatReady = fixed_pat[cyc % 5];
      endcase
      check_eq("beat_valid", 64'(bus.beatValid), 64'd1);
      check_eq("beat_id", 64'(bus.beatId), 64'(id));
      check_eq("beat_addr", 64'(bus.beatAddr), 64'(exp_addr(addr, len, size, burst, k)));
      check_eq("beat_idx", 64'(bus.beatIdx), 64'(k));
      check_eq("beat_last", 64'(bus.beatLast), 64'(k == int'(len)));
      check_eq("busy_in_burst", 64'(bus.busy), 64'd1);
      check_eq("axready_in_burst", 64'(bus.axready), 64'd0);
      @(posedge aclk);
      if (bus.beatReady) k++;
      cyc++;
      @(negedge aclk);
    end
    check_eq("beat_budget", 64'(cyc < 400), 64'd1);
    bus.beatReady = 1'b0;
    check_eq("end_valid", 64'(bus.beatValid), 64'd0);
    check_eq("end_busy", 64'(bus.busy), 64'd0);
    check_eq("end_axready", 64'(bus.axready), 64'd1);
    hs = k;
  endtask

  initial begin
    int hs;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    n_cmp = 0;
    n_err = 0;
    resetn        = 1'b0;
    bus.axid      = '0;
    bus.axaddr    = '0;
    bus.axlen     = '0;
    bus.axsize    = '0;
    bus.axburst   = '0;
    bus.axvalid   = 1'b0;
    bus.beatReady = 1'b0;

    @(negedge aclk);
    check_eq("rst_axready", 64'(bus.axready), 64'd0);
    check_eq("rst_valid", 64'(bus.beatValid), 64'd0);
    check_eq("rst_last", 64'(bus.beatLast), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_idx", 64'(bus.beatIdx), 64'd0);
    check_eq("rst_addr", 64'(bus.beatAddr), 64'd0);
    check_eq("rst_id", 64'(bus.beatId), 64'd0);
    resetn = 1'b1;
    @(negedge aclk);
    check_eq("post_rst_axready", 64'(bus.axready), 64'd1);

    // INCR aligned, full throughput
    send_desc(8'h11, 32'h1000, 8'd3, 3'd3, BURST_INCR);
    run_beats(8'h11, 32'h1000, 8'd3, 3'd3, BURST_INCR, 0, hs);

    // INCR unaligned start
    send_desc(8'h12, 32'h1003, 8'd2, 3'd2, BURST_INCR);
    run_beats(8'h12, 32'h1003, 8'd2, 3'd2, BURST_INCR, 0, hs);

    // WRAP (INCR when the feature is absent)
    send_desc(8'h13, 32'h2030, 8'd3, 3'd3, BURST_WRAP);
    run_beats(8'h13, 32'h2030, 8'd3, 3'd3, BURST_WRAP, 0, hs);

    // FIXED with backpressure
    send_desc(8'h14, 32'h40, 8'd2, 3'd2, BURST_FIXED);
    run_beats(8'h14, 32'h40, 8'd2, 3'd2, BURST_FIXED, 2, hs);
    check_eq("fixed_handshakes", 64'(hs), 64'd3);

    // Single beat with a second descriptor held during the burst
    send_desc(8'h15, 32'h80, 8'd0, 3'd2, BURST_INCR);
    bus.axid    = 8'h16;
    bus.axaddr  = 32'h300;
    bus.axlen   = 8'd1;
    bus.axsize  = 3'd2;
    bus.axburst = BURST_INCR;
    bus.axvalid = 1'b1;
    run_beats(8'h15, 32'h80, 8'd0, 3'd2, BURST_INCR, 2, hs);
    send_desc(8'h16, 32'h300, 8'd1, 3'd2, BURST_INCR);
    run_beats(8'h16, 32'h300, 8'd1, 3'd2, BURST_INCR, 0, hs);

    // Asynchronous reset in the middle of a burst
    send_desc(8'h17, 32'h100, 8'd7, 3'd2, BURST_INCR);
    @(negedge aclk);
    bus.beatReady = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check_eq("mid_idx", 64'(bus.beatIdx), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(bus.beatValid), 64'd0);
    check_eq("async_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("async_rst_axready", 64'(bus.axready), 64'd0);
    check_eq("async_rst_idx", 64'(bus.beatIdx), 64'd0);
    @(negedge aclk);
    bus.beatReady = 1'b0;
    resetn = 1'b1;
    @(negedge aclk);
    check_eq("rerst_axready", 64'(bus.axready), 64'd1);
    check_eq("rerst_valid", 64'(bus.beatValid), 64'd0);
    send_desc(8'h18, 32'h0, 8'd3, 3'd2, BURST_INCR);
    run_beats(8'h18, 32'h0, 8'd3, 3'd2, BURST_INCR, 0, hs);

    // Random bursts with random backpressure
    repeat (40) begin
      r_burst = 2'($urandom_range(0, 3));
      r_size  = 3'($urandom_range(0, 3));
      r_addr  = $urandom;
      if (r_burst == BURST_WRAP) r_len = (8'd2 << $urandom_range(0, 3)) - 8'd1;
      else r_len = 8'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge aclk);
      send_desc(8'($urandom), r_addr, r_len, r_size, r_burst);
      run_beats(bus.axid, r_addr, r_len, r_size, r_burst, 1, hs);
      check_eq("rand_handshakes", 64'(hs), 64'(r_len) + 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
